// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
// vga_capture : locks onto incoming VGA sync timing, streams frame-buffer writes
// Revision    : 1.0
// ============================================================================
module vga_capture #(
  parameter int H_TOTAL     = 794,
  parameter int V_TOTAL     = 526,
  parameter int H_ACT_START = 136,
  parameter int V_ACT_START = 36,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        c25,
  input  logic        Reset,
  input  logic        capture_en,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic [7:0]  vid_pixel,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [9:0]  row_out,
  output logic [9:0]  col_out,
  output logic        locked,
  output logic        frame_done,
  output logic        sync_err
);

  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] c_h_last  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] c_h_sat   = HW'(H_TOTAL);
  localparam logic [HW-1:0] c_h_first = HW'(H_ACT_START);
  localparam logic [HW-1:0] c_h_end   = HW'(H_ACT_START + H_ACT);
  localparam logic [VW-1:0] c_v_last  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] c_v_sat   = VW'(V_TOTAL);
  localparam logic [VW-1:0] c_v_first = VW'(V_ACT_START);
  localparam logic [VW-1:0] c_v_end   = VW'(V_ACT_START + V_ACT);
  localparam logic [18:0]   c_last_addr = 19'(H_ACT * V_ACT - 1);
  localparam logic [7:0]    c_lock_n    = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          hs_q, vs_q, hs_dly_q, vs_dly_q;
  logic [7:0]    pix_q;
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [18:0]   addr_q;

  logic          wr_en_q, frame_done_q, sync_err_q;
  logic [18:0]   wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [9:0]    row_q, col_q;

  logic          w_hs_fall, w_vs_fall, w_viol, w_in_win;

  // Sync regs idle at the inactive (high) level so a fall needs a real high->low step.
  always_ff @(posedge c25) begin
    if (Reset) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
      pix_q    <= '0;
    end else begin
      hs_q     <= vid_hs;
      vs_q     <= vid_vs;
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
      pix_q    <= vid_pixel;
    end
  end

  assign w_hs_fall = hs_dly_q & ~hs_q;
  assign w_vs_fall = vs_dly_q & ~vs_q;

  // hc_d/vc_d are the column/row of the pixel currently held in pix_q.
  always_comb begin
    hc_d   = hc_q;
    vc_d   = vc_q;
    w_viol = 1'b0;
    if (w_hs_fall) begin
      hc_d = '0;
      if (hc_q != c_h_last) w_viol = 1'b1;
    end else if (hc_q != c_h_sat) begin
      hc_d = hc_q + 1'b1;
      if (hc_q == c_h_last) w_viol = 1'b1;
    end
    if (w_vs_fall) begin
      vc_d = '0;
      if (!w_hs_fall || (vc_q != c_v_last)) w_viol = 1'b1;
    end else if (w_hs_fall && (vc_q != c_v_sat)) begin
      vc_d = vc_q + 1'b1;
      if (vc_q == c_v_last) w_viol = 1'b1;
    end
  end

  always_ff @(posedge c25) begin
    if (Reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (capture_en) state_d = ST_SEEK;
      end
      ST_SEEK: begin
        if (w_vs_fall) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
        end
      end
      ST_MEASURE: begin
        if (w_viol) begin
          state_d = ST_SEEK;
          cnt_d   = '0;
        end else if (w_vs_fall) begin
          if (cnt_q + 8'd1 == c_lock_n) begin
            state_d = capture_en ? ST_LOCKED : ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (w_viol)                         state_d = ST_SEEK;
        else if (w_vs_fall && !capture_en)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c25) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A violating cycle never writes, so an aborted frame stops on that very pixel.
  assign w_in_win = (state_q == ST_LOCKED) && !w_viol &&
                    (vc_d >= c_v_first) && (vc_d < c_v_end) &&
                    (hc_d >= c_h_first) && (hc_d < c_h_end);

  always_ff @(posedge c25) begin
    if (Reset) begin
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      if (w_vs_fall)     addr_q <= '0;
      else if (w_in_win) addr_q <= addr_q + 1'b1;
      wr_en_q <= w_in_win;
      if (w_in_win) begin
        wr_addr_q <= addr_q;
        wr_data_q <= pix_q;
        row_q     <= 10'(vc_d - c_v_first);
        col_q     <= 10'(hc_d - c_h_first);
      end
      frame_done_q <= wr_en_q && (wr_addr_q == c_last_addr);
      sync_err_q   <= w_viol && (state_q != ST_IDLE);
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign row_out    = row_q;
  assign col_out    = col_q;
  assign locked     = (state_q == ST_LOCKED);
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
// tb_vga_capture : reduced-geometry video source with a frame-level write model
// Revision       : 1.0
// ============================================================================
module tb_vga_capture;

  localparam int H_TOT = 40;
  localparam int V_TOT = 20;
  localparam int H_AS  = 8;
  localparam int V_AS  = 4;
  localparam int H_A   = 24;
  localparam int V_A   = 12;
  localparam int LOCKN = 2;
  localparam int HSW   = 4;
  localparam int FULL  = H_A * V_A;

  logic        c25 = 1'b0;
  logic        Reset, capture_en, vid_hs, vid_vs;
  logic [7:0]  vid_pixel;
  logic        wr_en, locked, frame_done, sync_err;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic [9:0]  row_out, col_out;

  vga_capture #(
    .H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .H_ACT_START(H_AS), .V_ACT_START(V_AS),
    .H_ACT(H_A), .V_ACT(V_A), .LOCK_FRAMES(LOCKN)
  ) dut (
    .c25(c25), .Reset(Reset), .capture_en(capture_en),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_pixel(vid_pixel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .row_out(row_out), .col_out(col_out), .locked(locked),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 c25 = ~c25;

  typedef struct packed {
    logic [31:0] cyc;
    logic [18:0] addr;
    logic [7:0]  data;
    logic [9:0]  row;
    logic [9:0]  col;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] fd_q[$];
  logic [31:0] cyc = '0;
  int n_checks = 0, n_errors = 0;
  int wr_cnt = 0, fd_cnt = 0, err_cnt = 0, lk_hi_cnt = 0;
  bit lk_row1;
  wr_t obs_w, exp_w;
  wire [50:0] all_outs = {wr_en, wr_addr, wr_data, row_out, col_out, locked, frame_done, sync_err};

  always @(posedge c25) cyc <= cyc + 1;

  // Every observed write is matched, in order and with exact cycle, to the model.
  always @(negedge c25) begin
    if (locked)   lk_hi_cnt++;
    if (sync_err) err_cnt++;
    if (wr_en) begin
      wr_cnt++;
      n_checks++;
      obs_w = '{cyc: cyc, addr: wr_addr, data: wr_data, row: row_out, col: col_out};
      if (exp_q.size() == 0) begin
        assert (0) else begin
          n_errors++;
          $error("FAIL unexpected_write: observed addr=%0d row=%0d col=%0d required none", wr_addr, row_out, col_out);
        end
      end else begin
        exp_w = exp_q.pop_front();
        assert (obs_w === exp_w) else begin
          n_errors++;
          $error("FAIL write: observed cyc=%0d addr=%0d data=%0h row=%0d col=%0d required cyc=%0d addr=%0d data=%0h row=%0d col=%0d",
                 obs_w.cyc, obs_w.addr, obs_w.data, obs_w.row, obs_w.col,
                 exp_w.cyc, exp_w.addr, exp_w.data, exp_w.row, exp_w.col);
        end
      end
    end
    if (frame_done) begin
      fd_cnt++;
      n_checks++;
      assert ((fd_q.size() != 0) && (fd_q[0] === cyc)) else begin
        n_errors++;
        $error("FAIL frame_done_time: observed cyc=%0d required cyc=%0d", cyc, (fd_q.size() != 0) ? fd_q[0] : 32'hFFFF_FFFF);
      end
      if (fd_q.size() != 0) void'(fd_q.pop_front());
    end
  end

  task automatic check_int(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  // One source frame: row 0 starts with HS and VS falling together (shifted by vs_off).
  task automatic drive_frame(input bit capt, input int abort_row, input int short_row,
                             input int vs_off, input bit col_pix, input int en_row,
                             input bit en_val, input int rst_row);
    for (int r = 0; r < V_TOT; r++) begin
      int len;
      len = (r == short_row) ? H_TOT - 1 : H_TOT;
      for (int c = 0; c < len; c++) begin
        int p;
        logic [7:0] pix;
        logic [31:0] cv;
        p = r * H_TOT + c;
        @(posedge c25); #1;
        if (r == rst_row && c == 1) begin
          n_checks++;
          assert (all_outs === '0) else begin
            n_errors++;
            $error("FAIL reset_midframe_outputs: observed %0h required 0", all_outs);
          end
        end
        Reset = (r == rst_row) && (c == 0);
        if (r == en_row && c == 0) capture_en = en_val;
        if (r == 1 && c == 0) lk_row1 = locked;
        cv = c;
        vid_hs = !(c < HSW);
        vid_vs = !((p >= vs_off) && (p < vs_off + 2 * H_TOT));
        pix = col_pix ? cv[7:0] : 8'($urandom);
        vid_pixel = pix;
        if (capt && (r >= V_AS) && (r < V_AS + V_A) && (c >= H_AS) && (c < H_AS + H_A) &&
            ((abort_row < 0) || (r <= abort_row))) begin
          int a;
          a = (r - V_AS) * H_A + (c - H_AS);
          exp_q.push_back('{cyc: cyc + 2, addr: 19'(a), data: pix, row: 10'(r - V_AS), col: 10'(c - H_AS)});
          if (a == FULL - 1) fd_q.push_back(cyc + 3);
        end
      end
    end
  endtask

  task automatic run_frame(input string tag, input bit capt, input int abort_row,
                           input int short_row, input int vs_off, input bit col_pix,
                           input int en_row, input bit en_val, input int rst_row,
                           input int exp_wr, input int exp_fd);
    int w0, f0;
    w0 = wr_cnt;
    f0 = fd_cnt;
    drive_frame(capt, abort_row, short_row, vs_off, col_pix, en_row, en_val, rst_row);
    check_int({tag, "_writes"}, wr_cnt - w0, exp_wr);
    check_int({tag, "_frame_done"}, fd_cnt - f0, exp_fd);
    check_int({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int e0, l0;
    Reset = 1'b1; capture_en = 1'b0; vid_hs = 1'b1; vid_vs = 1'b1; vid_pixel = '0;
    repeat (3) @(posedge c25);
    #1;
    n_checks++;
    assert (all_outs === '0) else begin
      n_errors++;
      $error("FAIL reset_state: observed %0h required 0", all_outs);
    end
    Reset = 1'b0;

    // Nominal lock: enable in frame 0, VS falls at frames 1,2,3; frame 3 captured.
    run_frame("f0", 0, -1, -1, 0, 0, 5, 1, -1, 0, 0);
    run_frame("f1", 0, -1, -1, 0, 0, -1, 0, -1, 0, 0);
    run_frame("f2", 0, -1, -1, 0, 0, -1, 0, -1, 0, 0);
    check_int("f2_locked_row1", lk_row1, 0);
    e0 = err_cnt;
    run_frame("f3", 1, -1, -1, 0, 0, -1, 0, -1, FULL, 1);
    check_int("f3_locked_row1", lk_row1, 1);
    run_frame("f4_colpix", 1, -1, -1, 0, 1, -1, 0, -1, FULL, 1);
    check_int("clean_sync_err", err_cnt - e0, 0);

    // Short line at row 6: abort from row 7, relock two frames later.
    e0 = err_cnt;
    run_frame("f5_short", 1, 6, 6, 0, 0, -1, 0, -1, (6 - V_AS + 1) * H_A, 0);
    check_int("short_sync_err", err_cnt - e0, 1);
    check_int("short_locked", locked, 0);
    run_frame("f6", 0, -1, -1, 0, 0, -1, 0, -1, 0, 0);
    run_frame("f7", 0, -1, -1, 0, 0, -1, 0, -1, 0, 0);
    run_frame("f8_relock", 1, -1, -1, 0, 0, -1, 0, -1, FULL, 1);

    // Disable mid-frame: frame completes, IDLE from the next VS fall.
    run_frame("f9_disable", 1, -1, -1, 0, 0, 8, 0, -1, FULL, 1);
    run_frame("f10_idle", 0, -1, -1, 0, 0, 10, 1, -1, 0, 0);
    check_int("f10_locked_row1", lk_row1, 0);
    run_frame("f11", 0, -1, -1, 0, 0, -1, 0, -1, 0, 0);
    run_frame("f12", 0, -1, -1, 0, 0, -1, 0, -1, 0, 0);

    // Reset mid-frame at row 8: rows 4..7 written, then relock.
    run_frame("f13_reset", 1, 7, -1, 0, 0, -1, 0, 8, (7 - V_AS + 1) * H_A, 0);
    check_int("f13_locked_after_reset", locked, 0);
    run_frame("f14", 0, -1, -1, 0, 0, -1, 0, -1, 0, 0);
    run_frame("f15", 0, -1, -1, 0, 0, -1, 0, -1, 0, 0);
    run_frame("f16_relock", 1, -1, -1, 0, 0, -1, 0, -1, FULL, 1);

    // VS falls 5 cycles after HS: never locks.
    run_frame("f17_vsmis", 0, -1, -1, 5, 0, -1, 0, -1, 0, 0);
    check_int("vsmis_locked", locked, 0);
    e0 = err_cnt;
    l0 = lk_hi_cnt;
    run_frame("f18_vsmis", 0, -1, -1, 5, 0, -1, 0, -1, 0, 0);
    run_frame("f19_vsmis", 0, -1, -1, 5, 0, -1, 0, -1, 0, 0);
    run_frame("f20_vsmis", 0, -1, -1, 5, 0, -1, 0, -1, 0, 0);
    check_int("vsmis_locked_cycles", lk_hi_cnt - l0, 0);
    check_int("vsmis_sync_err_seen", (err_cnt - e0) >= 3 ? 1 : 0, 1);
    check_int("fd_pending", fd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
